// File: rtl/dl_pkg.sv
// Shared types and address-mapping helpers for the ROM download sequencer.
package dl_pkg;

  localparam logic [24:0] SP_BASE_DEF = 25'h10000;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
  } port_addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dl_state_t;

  typedef enum logic {
    PORT1 = 1'b0,
    PORT2 = 1'b1
  } port_sel_t;

  // Plain 16-bit word addressing: the low byte-address bit selects the lane.
  function automatic port_addr_t port1_map(input logic [23:0] addr);
    port_addr_t m;
    m.a  = addr[23:1];
    m.ds = {addr[0], ~addr[0]};
    return m;
  endfunction

  // Sprite ROMs are interleaved so that two 16-bit planes merge into a 32-bit fetch.
  function automatic port_addr_t sp_map(input logic [23:0] s);
    port_addr_t m;
    m.a  = {s[23:16], s[13:0], s[15]};
    m.ds = {s[14], ~s[14]};
    return m;
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// First-word-fall-through FIFO of download entries; push and pop may coincide
// in any state, including full.
module dl_fifo
  import dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t dout,
  output logic        full,
  output logic        empty
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == FULL_CNT);
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    do_push  = push && (!full || do_pop);
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign dout = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rom_dl_sequencer.sv
// Sequences data_io ROM download bytes into the two SDRAM write ports, one
// outstanding toggle request at a time, and owns rom_loaded and the core reset.
module rom_dl_sequencer
  import dl_pkg::*;
#(
  parameter logic [24:0] SP_BASE    = SP_BASE_DEF,
  parameter int          FIFO_DEPTH = 4,
  parameter int          RST_CNT_W  = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        user_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic        busy,
  output logic        overflow,
  output logic        rom_loaded,
  output logic        core_reset
);

  logic                 wr_q, dl_q;
  logic                 push, pop, drop;
  logic                 dl_rise, dl_fall;
  fifo_entry_t          push_entry, head;
  logic                 fifo_full, fifo_empty;
  logic [23:0]          sp_off;
  port_sel_t            head_port;
  port_addr_t           head_map;

  dl_state_t            state_q, state_d;
  port_sel_t            sel_q, sel_d;
  logic                 p1_req_q, p1_req_d;
  logic [22:0]          p1_a_q, p1_a_d;
  logic [1:0]           p1_ds_q, p1_ds_d;
  logic [15:0]          p1_d_q, p1_d_d;
  logic                 p2_req_q, p2_req_d;
  logic [22:0]          p2_a_q, p2_a_d;
  logic [1:0]           p2_ds_q, p2_ds_d;
  logic [15:0]          p2_d_q, p2_d_d;
  logic                 we_q, we_d;
  logic                 overflow_q, overflow_d;
  logic                 armed_q, armed_d;
  logic                 rom_loaded_q, rom_loaded_d;
  logic [RST_CNT_W-1:0] cnt_q, cnt_d;
  logic                 core_reset_q, core_reset_d;

  assign push       = ioctl_download && ioctl_wr && !wr_q;
  assign push_entry = '{addr: ioctl_addr, data: ioctl_dout};
  assign dl_rise    = ioctl_download && !dl_q;
  assign dl_fall    = !ioctl_download && dl_q;

  dl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    sp_off = 24'(head.addr - SP_BASE);
    if (head.addr < SP_BASE) begin
      head_port = PORT1;
      head_map  = port1_map(head.addr[23:0]);
    end else begin
      head_port = PORT2;
      head_map  = sp_map(sp_off);
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    p1_req_d = p1_req_q;
    p1_a_d   = p1_a_q;
    p1_ds_d  = p1_ds_q;
    p1_d_d   = p1_d_q;
    p2_req_d = p2_req_q;
    p2_a_d   = p2_a_q;
    p2_ds_d  = p2_ds_q;
    p2_d_d   = p2_d_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sel_d   = head_port;
          state_d = WAIT;
          if (head_port == PORT1) begin
            p1_req_d = ~p1_req_q;
            p1_a_d   = head_map.a;
            p1_ds_d  = head_map.ds;
            p1_d_d   = {head.data, head.data};
          end else begin
            p2_req_d = ~p2_req_q;
            p2_a_d   = head_map.a;
            p2_ds_d  = head_map.ds;
            p2_d_d   = {head.data, head.data};
          end
        end
      end
      WAIT: begin
        if ((sel_q == PORT1 && port1_ack == p1_req_q) ||
            (sel_q == PORT2 && port2_ack == p2_req_q)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = !fifo_empty || (state_q != IDLE);
    drop = push && fifo_full && !pop;
    we_d = ioctl_download || busy;

    overflow_d = overflow_q;
    if (dl_rise) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;

    // Completion waits for the FIFO and the last SDRAM write to drain.
    armed_d      = armed_q;
    rom_loaded_d = rom_loaded_q;
    if (dl_fall) armed_d = 1'b1;
    if (armed_q && fifo_empty && state_q == IDLE) begin
      armed_d      = 1'b0;
      rom_loaded_d = 1'b1;
    end
    if (dl_rise) begin
      armed_d      = 1'b0;
      rom_loaded_d = 1'b0;
    end

    if (user_reset || !rom_loaded_q) cnt_d = '1;
    else if (cnt_q != '0)            cnt_d = cnt_q - 1'b1;
    else                             cnt_d = cnt_q;
    core_reset_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_q         <= 1'b0;
      dl_q         <= 1'b0;
      state_q      <= IDLE;
      sel_q        <= PORT1;
      p1_req_q     <= 1'b0;
      p1_a_q       <= '0;
      p1_ds_q      <= '0;
      p1_d_q       <= '0;
      p2_req_q     <= 1'b0;
      p2_a_q       <= '0;
      p2_ds_q      <= '0;
      p2_d_q       <= '0;
      we_q         <= 1'b0;
      overflow_q   <= 1'b0;
      armed_q      <= 1'b0;
      rom_loaded_q <= 1'b0;
      cnt_q        <= '1;
      core_reset_q <= 1'b1;
    end else begin
      wr_q         <= ioctl_wr;
      dl_q         <= ioctl_download;
      state_q      <= state_d;
      sel_q        <= sel_d;
      p1_req_q     <= p1_req_d;
      p1_a_q       <= p1_a_d;
      p1_ds_q      <= p1_ds_d;
      p1_d_q       <= p1_d_d;
      p2_req_q     <= p2_req_d;
      p2_a_q       <= p2_a_d;
      p2_ds_q      <= p2_ds_d;
      p2_d_q       <= p2_d_d;
      we_q         <= we_d;
      overflow_q   <= overflow_d;
      armed_q      <= armed_d;
      rom_loaded_q <= rom_loaded_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign port1_req  = p1_req_q;
  assign port1_a    = p1_a_q;
  assign port1_ds   = p1_ds_q;
  assign port1_d    = p1_d_q;
  assign port1_we   = we_q;
  assign port2_req  = p2_req_q;
  assign port2_a    = p2_a_q;
  assign port2_ds   = p2_ds_q;
  assign port2_d    = p2_d_q;
  assign port2_we   = we_q;
  assign overflow   = overflow_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;

endmodule
